// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, redirect and decode-handshake signals of the fetch stage.
interface fetch_unit_if #(parameter int DEPTH = 4);
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] branch_offset;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [$clog2(DEPTH):0] buf_count;
  modport master (
    output imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, buf_count,
    input imem_instr, branch_taken, branch_pc, branch_offset, out_ready
  );
  modport slave (
    input imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, buf_count,
    output imem_instr, branch_taken, branch_pc, branch_offset, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and fetch FIFO feeding decode; FETCH_BYPASS_EN adds a zero-latency empty-FIFO path.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  fetch_unit_if.master io_fu
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] r_pc;
  logic [31:0] r_mem_instr [DEPTH];
  logic [31:0] r_mem_pc [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count;
  logic [31:0] r_last_instr, r_last_pc;
  logic w_empty, w_full, w_valid, w_pop, w_pop_fifo, w_push, w_write;
  logic [31:0] w_instr, w_pc, w_target;
  assign w_empty = r_count == '0;
  assign w_full = r_count == (AW+1)'(DEPTH);
`ifdef FETCH_BYPASS_EN
  logic w_byp;
  assign w_byp = w_empty && !io_fu.branch_taken;
  assign w_valid = !w_empty || w_byp;
  assign w_instr = !w_empty ? r_mem_instr[r_rp] : w_byp ? io_fu.imem_instr : r_last_instr;
  assign w_pc = !w_empty ? r_mem_pc[r_rp] : w_byp ? r_pc : r_last_pc;
  assign w_write = w_push && !(w_byp && io_fu.out_ready);
`else
  assign w_valid = !w_empty;
  assign w_instr = w_empty ? r_last_instr : r_mem_instr[r_rp];
  assign w_pc = w_empty ? r_last_pc : r_mem_pc[r_rp];
  assign w_write = w_push;
`endif
  assign w_pop = w_valid && io_fu.out_ready;
  assign w_pop_fifo = w_pop && !w_empty;
  assign w_push = !w_full || w_pop;
  assign w_target = io_fu.branch_pc + 32'd4 + (io_fu.branch_offset << 2);
  assign io_fu.imem_addr = r_pc >> 2;
  assign io_fu.out_valid = w_valid;
  assign io_fu.out_instr = w_instr;
  assign io_fu.out_pc = w_pc;
  assign io_fu.out_pc_plus4 = w_pc + 32'd4;
  assign io_fu.buf_count = r_count;
  always_ff @(posedge clk) begin
    if (w_write && !io_fu.branch_taken) begin
      r_mem_instr[r_wp] <= io_fu.imem_instr;
      r_mem_pc[r_wp] <= r_pc;
    end
  end
  // r_last_* keeps the most recently presented word so outputs hold while empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
      r_last_instr <= '0;
      r_last_pc <= '0;
    end else begin
      if (w_valid) begin
        r_last_instr <= w_instr;
        r_last_pc <= w_pc;
      end
      if (io_fu.branch_taken) begin
        r_pc <= w_target;
        r_wp <= '0;
        r_rp <= '0;
        r_count <= '0;
      end else begin
        r_pc <= w_push ? r_pc + 32'd4 : r_pc;
        r_wp <= w_write ? r_wp + AW'(1) : r_wp;
        r_rp <= w_pop_fifo ? r_rp + AW'(1) : r_rp;
        r_count <= r_count + (AW+1)'(w_write) - (AW+1)'(w_pop_fifo);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue-based reference model checked every cycle.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fetch_unit_if #(.DEPTH(4)) ifm ();
  fetch_unit_if #(.DEPTH(4)) if2 ();
  fetch_unit #(.RESET_PC(32'd0), .DEPTH(4)) dut (.clk(clk), .rst(rst), .io_fu(ifm.master));
  fetch_unit #(.RESET_PC(32'hFFFFFFFC), .DEPTH(4)) dut2 (.clk(clk), .rst(rst), .io_fu(if2.master));
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h12345678;
  endfunction
  assign ifm.imem_instr = memf(ifm.imem_addr);
  assign if2.imem_instr = memf(if2.imem_addr);
  assign if2.branch_taken = 1'b0;
  assign if2.branch_pc = '0;
  assign if2.branch_offset = '0;
  assign if2.out_ready = 1'b1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  logic [31:0] qi[$];
  logic [31:0] qp[$];
  logic [31:0] mpc = 32'd0;
  logic [31:0] mlast_i = 32'd0;
  logic [31:0] mlast_p = 32'd0;
  always @(posedge clk) begin
    if (rst) begin
      qi.delete();
      qp.delete();
      mpc = 32'd0;
      mlast_i = 32'd0;
      mlast_p = 32'd0;
    end else begin
      bit pop, push;
      if (qi.size() > 0) begin
        mlast_i = qi[0];
        mlast_p = qp[0];
      end
      if (ifm.branch_taken) begin
        qi.delete();
        qp.delete();
        mpc = ifm.branch_pc + 32'd4 + (ifm.branch_offset << 2);
      end else begin
        pop = qi.size() > 0 && ifm.out_ready;
        push = qi.size() < 4 || pop;
        if (pop) begin
          void'(qi.pop_front());
          void'(qp.pop_front());
        end
        if (push) begin
          qi.push_back(memf(mpc >> 2));
          qp.push_back(mpc);
          mpc = mpc + 32'd4;
        end
      end
    end
  end
  always @(negedge clk) begin
    logic [31:0] ei, ep;
    if (rst) begin
      chk("rst_valid", 32'(ifm.out_valid), 32'd0);
      chk("rst_instr", ifm.out_instr, 32'd0);
      chk("rst_pc", ifm.out_pc, 32'd0);
      chk("rst_pc4", ifm.out_pc_plus4, 32'd4);
      chk("rst_count", 32'(ifm.buf_count), 32'd0);
    end else begin
      ei = qi.size() > 0 ? qi[0] : mlast_i;
      ep = qp.size() > 0 ? qp[0] : mlast_p;
      chk("m_valid", 32'(ifm.out_valid), 32'(qi.size() > 0));
      chk("m_count", 32'(ifm.buf_count), 32'(qi.size()));
      chk("m_addr", ifm.imem_addr, mpc >> 2);
      chk("m_instr", ifm.out_instr, ei);
      chk("m_pc", ifm.out_pc, ep);
      chk("m_pc4", ifm.out_pc_plus4, ep + 32'd4);
    end
  end
  initial begin
    rst = 1'b1;
    ifm.out_ready = 1'b1;
    ifm.branch_taken = 1'b0;
    ifm.branch_pc = '0;
    ifm.branch_offset = '0;
    repeat (2) @(negedge clk);
    chk("lit_rst_valid", 32'(ifm.out_valid), 32'd0);
    chk("lit_rst_pc4", ifm.out_pc_plus4, 32'd4);
    chk("lit_rst_addr", ifm.imem_addr, 32'd0);
    chk("lit_rst2_pc", if2.out_pc, 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("seq_valid", 32'(ifm.out_valid), 32'd1);
      chk("seq_pc", ifm.out_pc, 32'(4 * i));
      chk("seq_instr", ifm.out_instr, memf(32'(i)));
      chk("wrap_pc", if2.out_pc, 32'hFFFFFFFC + 32'(4 * i));
      chk("wrap_instr", if2.out_instr, memf((32'hFFFFFFFC + 32'(4 * i)) >> 2));
    end
    #1 rst = 1'b1;
    #1;
    chk("async_valid", 32'(ifm.out_valid), 32'd0);
    chk("async_count", 32'(ifm.buf_count), 32'd0);
    chk("async_addr", ifm.imem_addr, 32'd0);
    chk("async_pc", ifm.out_pc, 32'd0);
    ifm.out_ready = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("bp_count", 32'(ifm.buf_count), 32'd4);
    chk("bp_addr", ifm.imem_addr, 32'd4);
    chk("bp_head", ifm.out_pc, 32'd0);
    ifm.out_ready = 1'b1;
    for (int j = 1; j < 6; j++) begin
      @(negedge clk);
      chk("drain_pc", ifm.out_pc, 32'(4 * j));
      chk("drain_instr", ifm.out_instr, memf(32'(j)));
    end
    #1 rst = 1'b1;
    ifm.out_ready = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("br_pre_count", 32'(ifm.buf_count), 32'd3);
    ifm.branch_taken = 1'b1;
    ifm.branch_pc = 32'h10;
    ifm.branch_offset = 32'hFFFFFFFE;
    @(negedge clk);
    ifm.branch_taken = 1'b0;
    chk("br_bubble", 32'(ifm.out_valid), 32'd0);
    chk("br_flush", 32'(ifm.buf_count), 32'd0);
    @(negedge clk);
    chk("br_valid", 32'(ifm.out_valid), 32'd1);
    chk("br_target", ifm.out_pc, 32'h0C);
    chk("br_instr", ifm.out_instr, memf(32'd3));
    ifm.out_ready = 1'b1;
    @(negedge clk);
    chk("br_next", ifm.out_pc, 32'h10);
    ifm.out_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("full_count", 32'(ifm.buf_count), 32'd4);
    ifm.out_ready = 1'b1;
    ifm.branch_taken = 1'b1;
    ifm.branch_pc = 32'h100;
    ifm.branch_offset = 32'd4;
    @(negedge clk);
    ifm.branch_taken = 1'b0;
    chk("rp_bubble", 32'(ifm.out_valid), 32'd0);
    @(negedge clk);
    chk("rp_target", ifm.out_pc, 32'h114);
    @(negedge clk);
    chk("rp_next", ifm.out_pc, 32'h118);
    chk("rp_instr", ifm.out_instr, memf(32'h118 >> 2));
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
